// File: rtl/tlb_unit_if.sv
`timescale 1ns/1ps
// CP0-facing op/response signals plus the L1 lookup channels of tlb_unit.
// Handshake: an op is taken on a rising edge with op_valid && op_ready; op inputs are sampled only on that edge.
interface tlb_unit_if #(
  parameter int NR_ENTRY = 32,
  parameter int NR_PORT  = 3
);
  localparam int IDX_W = $clog2(NR_ENTRY);

  logic                  op_valid;
  logic                  op_ready;
  logic [1:0]            op_code;
  logic [IDX_W-1:0]      op_index;
  logic [26:0]           entryhi_in;
  logic [25:0]           entrylo0_in;
  logic [25:0]           entrylo1_in;
  logic [IDX_W-1:0]      wired;
  logic                  wired_we;
  logic [IDX_W-1:0]      random_out;
  logic                  resp_valid;
  logic                  resp_hit;
  logic                  resp_multi;
  logic [IDX_W-1:0]      resp_index;
  logic [26:0]           resp_entryhi;
  logic [25:0]           resp_entrylo0;
  logic [25:0]           resp_entrylo1;
  logic                  fence;
  logic [7:0]            cur_asid;
  logic [NR_PORT-1:0]    lk_req;
  logic [20*NR_PORT-1:0] lk_vpn;
  logic [NR_PORT-1:0]    lk_hit;
  logic [NR_PORT-1:0]    lk_v;
  logic [NR_PORT-1:0]    lk_d;
  logic [20*NR_PORT-1:0] lk_pfn;
  logic [3*NR_PORT-1:0]  lk_c;
  logic [2:0]            fsm_state;

  modport master (
    output op_valid, op_code, op_index, entryhi_in, entrylo0_in, entrylo1_in,
           wired, wired_we, cur_asid, lk_req, lk_vpn,
    input  op_ready, random_out, resp_valid, resp_hit, resp_multi, resp_index,
           resp_entryhi, resp_entrylo0, resp_entrylo1, fence,
           lk_hit, lk_v, lk_d, lk_pfn, lk_c, fsm_state
  );

  modport slave (
    input  op_valid, op_code, op_index, entryhi_in, entrylo0_in, entrylo1_in,
           wired, wired_we, cur_asid, lk_req, lk_vpn,
    output op_ready, random_out, resp_valid, resp_hit, resp_multi, resp_index,
           resp_entryhi, resp_entrylo0, resp_entrylo1, fence,
           lk_hit, lk_v, lk_d, lk_pfn, lk_c, fsm_state
  );
endinterface

// File: rtl/tlb_unit.sv
`timescale 1ns/1ps
// Joint TLB: NR_ENTRY dual-page entries, NR_PORT one-cycle lookup channels,
// TLBP/TLBR/TLBWI/TLBWR op FSM, Random counter and post-write fence pulse.
module tlb_unit #(
  parameter int NR_ENTRY = 32,
  parameter int NR_PORT  = 3
) (
  input logic       clk,
  input logic       rst,
  tlb_unit_if.slave bus
);
  localparam int IDX_W = $clog2(NR_ENTRY);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NR_ENTRY - 1);
  localparam logic [1:0] OP_TLBP = 2'd0;
  localparam logic [1:0] OP_TLBR = 2'd1;

  typedef enum logic [2:0] {IDLE, P_CMP, P_ENC, RD, WR} state_t;

  typedef struct packed {
    logic        present;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  state_t                    state;
  entry_t                    tlb [NR_ENTRY];
  entry_t                    w_entry;
  entry_t                    r_entry;
  logic [NR_ENTRY-1:0]       p_vec;
  logic [NR_ENTRY-1:0]       p_vec_q;
  logic [IDX_W-1:0]          p_idx;
  logic [IDX_W-1:0]          w_idx;
  logic [NR_PORT-1:0]        l_hit, l_v, l_d;
  logic [NR_PORT-1:0][19:0]  l_pfn;
  logic [NR_PORT-1:0][2:0]   l_c;

  function automatic logic match(entry_t e, logic [18:0] vpn2, logic [7:0] asid);
    return e.present && (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  assign bus.op_ready  = (state == IDLE);
  assign bus.fsm_state = state;
  // op_code[0] separates TLBWR (random slot) from TLBWI (Index slot).
  assign w_idx   = bus.op_code[0] ? bus.random_out : bus.op_index;
  assign r_entry = tlb[bus.op_index];

  always_comb begin
    w_entry         = '0;
    w_entry.present = 1'b1;
    w_entry.vpn2    = bus.entryhi_in[26:8];
    w_entry.asid    = bus.entryhi_in[7:0];
    w_entry.g       = bus.entrylo0_in[0] & bus.entrylo1_in[0];
    w_entry.pfn0    = bus.entrylo0_in[25:6];
    w_entry.c0      = bus.entrylo0_in[5:3];
    w_entry.d0      = bus.entrylo0_in[2];
    w_entry.v0      = bus.entrylo0_in[1];
    w_entry.pfn1    = bus.entrylo1_in[25:6];
    w_entry.c1      = bus.entrylo1_in[5:3];
    w_entry.d1      = bus.entrylo1_in[2];
    w_entry.v1      = bus.entrylo1_in[1];
  end

  always_comb begin
    p_vec = '0;
    for (int i = 0; i < NR_ENTRY; i++)
      p_vec[i] = match(tlb[i], bus.entryhi_in[26:8], bus.entryhi_in[7:0]);
  end

  always_comb begin
    p_idx = '0;
    for (int i = NR_ENTRY - 1; i >= 0; i--)
      if (p_vec_q[i]) p_idx = IDX_W'(i);
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    l_hit = '0;
    l_v   = '0;
    l_d   = '0;
    l_pfn = '0;
    l_c   = '0;
    for (int p = 0; p < NR_PORT; p++) begin
      for (int i = NR_ENTRY - 1; i >= 0; i--) begin
        if (match(tlb[i], bus.lk_vpn[20*p+1 +: 19], bus.cur_asid)) begin
          l_hit[p] = 1'b1;
          l_pfn[p] = bus.lk_vpn[20*p] ? tlb[i].pfn1 : tlb[i].pfn0;
          l_c[p]   = bus.lk_vpn[20*p] ? tlb[i].c1   : tlb[i].c0;
          l_d[p]   = bus.lk_vpn[20*p] ? tlb[i].d1   : tlb[i].d0;
          l_v[p]   = bus.lk_vpn[20*p] ? tlb[i].v1   : tlb[i].v0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.lk_hit <= '0;
      bus.lk_v   <= '0;
      bus.lk_d   <= '0;
      bus.lk_pfn <= '0;
      bus.lk_c   <= '0;
    end else begin
      for (int p = 0; p < NR_PORT; p++) begin
        if (bus.lk_req[p]) begin
          bus.lk_hit[p]          <= l_hit[p];
          bus.lk_v[p]            <= l_v[p];
          bus.lk_d[p]            <= l_d[p];
          bus.lk_pfn[20*p +: 20] <= l_pfn[p];
          bus.lk_c[3*p +: 3]     <= l_c[p];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.random_out <= IDX_MAX;
    else if (bus.wired_we || (bus.random_out <= bus.wired))
      bus.random_out <= IDX_MAX;
    else
      bus.random_out <= bus.random_out - 1'b1;
  end

  // Writes commit on the acceptance edge, so WR only carries the response/fence pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      p_vec_q           <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_hit      <= 1'b0;
      bus.resp_multi    <= 1'b0;
      bus.resp_index    <= '0;
      bus.resp_entryhi  <= '0;
      bus.resp_entrylo0 <= '0;
      bus.resp_entrylo1 <= '0;
      bus.fence         <= 1'b0;
      for (int i = 0; i < NR_ENTRY; i++) tlb[i] <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.fence      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_code)
              OP_TLBP: begin
                p_vec_q <= p_vec;
                state   <= P_CMP;
              end
              OP_TLBR: begin
                state             <= RD;
                bus.resp_valid    <= 1'b1;
                bus.resp_hit      <= 1'b0;
                bus.resp_multi    <= 1'b0;
                bus.resp_index    <= '0;
                bus.resp_entryhi  <= {r_entry.vpn2, r_entry.asid};
                bus.resp_entrylo0 <= {r_entry.pfn0, r_entry.c0, r_entry.d0, r_entry.v0, r_entry.g};
                bus.resp_entrylo1 <= {r_entry.pfn1, r_entry.c1, r_entry.d1, r_entry.v1, r_entry.g};
              end
              default: begin
                tlb[w_idx]        <= w_entry;
                state             <= WR;
                bus.resp_valid    <= 1'b1;
                bus.fence         <= 1'b1;
                bus.resp_hit      <= 1'b0;
                bus.resp_multi    <= 1'b0;
                bus.resp_index    <= '0;
                bus.resp_entryhi  <= '0;
                bus.resp_entrylo0 <= '0;
                bus.resp_entrylo1 <= '0;
              end
            endcase
          end
        end
        P_CMP: begin
          state             <= P_ENC;
          bus.resp_valid    <= 1'b1;
          bus.resp_hit      <= |p_vec_q;
          bus.resp_multi    <= |(p_vec_q & (p_vec_q - 1'b1));
          bus.resp_index    <= p_idx;
          bus.resp_entryhi  <= '0;
          bus.resp_entrylo0 <= '0;
          bus.resp_entrylo1 <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_unit.sv
`timescale 1ns/1ps
// Bench for tlb_unit: scenario tasks drive ops and lookups at the falling edge;
// expected op responses go through exp_q and are popped when resp_valid is seen.
module tb_tlb_unit;
  localparam int NR_ENTRY = 32;
  localparam int NR_PORT  = 3;
  localparam int RW       = 87;
  localparam logic [1:0] TLBP = 2'd0, TLBR = 2'd1, TLBWI = 2'd2, TLBWR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] r_write;

  tlb_unit_if #(.NR_ENTRY(NR_ENTRY), .NR_PORT(NR_PORT)) bus ();
  tlb_unit #(.NR_ENTRY(NR_ENTRY), .NR_PORT(NR_PORT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected finish before 400us");
    $fatal(1);
  end

  function automatic logic [25:0] lo(logic [19:0] pfn, logic [2:0] c, logic d, logic v, logic g);
    return {pfn, c, d, v, g};
  endfunction

  function automatic logic [RW-1:0] mk(logic hit, logic multi, logic [4:0] idx, logic [26:0] hi,
                                      logic [25:0] l0, logic [25:0] l1, logic fence);
    return {hit, multi, idx, hi, l0, l1, fence};
  endfunction

  function automatic logic [RW-1:0] resp_now();
    return {bus.resp_hit, bus.resp_multi, bus.resp_index, bus.resp_entryhi,
            bus.resp_entrylo0, bus.resp_entrylo1, bus.fence};
  endfunction

  // Called at a falling edge in IDLE; returns at a falling edge back in IDLE.
  task automatic run_op(input logic [1:0] code, input logic [4:0] idx, input logic [26:0] hi,
                        input logic [25:0] l0, input logic [25:0] l1,
                        output logic [RW-1:0] got, output int lat);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_index = idx;
    bus.entryhi_in = hi; bus.entrylo0_in = l0; bus.entrylo1_in = l1;
    @(negedge clk);
    bus.op_valid    = 1'b0;
    bus.op_code     = 2'($urandom_range(0, 3));
    bus.op_index    = 5'($urandom_range(0, 31));
    bus.entryhi_in  = 27'($urandom);
    bus.entrylo0_in = 26'($urandom);
    bus.entrylo1_in = 26'($urandom);
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) lat = -1;
    got = resp_now();
    @(negedge clk);
  endtask

  // Result packed as {hit, v, d, pfn, c}.
  task automatic lookup(input int p, input logic [19:0] vpn, input logic [7:0] asid,
                        output logic [25:0] res);
    bus.lk_req[p] = 1'b1; bus.lk_vpn[20*p +: 20] = vpn; bus.cur_asid = asid;
    @(negedge clk);
    bus.lk_req[p] = 1'b0;
    res = {bus.lk_hit[p], bus.lk_v[p], bus.lk_d[p], bus.lk_pfn[20*p +: 20], bus.lk_c[3*p +: 3]};
  endtask

  task automatic test_reset();
    logic [RW-1:0] got, exp;
    logic [25:0] lk;
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.random_out !== 5'd31) begin n_fail++; $display("FAIL reset_random: got %0d expected 31", bus.random_out); end
    n_checks++; if ({bus.resp_valid, bus.fence, bus.lk_hit} !== 5'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0", {bus.resp_valid, bus.fence, bus.lk_hit}); end
    n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.op_ready); end
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back('0);
    run_op(TLBP, 5'd0, 27'd0, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL reset_tlbp: got %h expected %h", got, exp); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL reset_tlbp_latency: got %0d expected 2", lat); end
    for (int p = 0; p < NR_PORT; p++) begin
      lookup(p, 20'h2468B, 8'd3, lk);
      n_checks++; if (lk !== 26'd0) begin n_fail++; $display("FAIL reset_lookup_p%0d: got %h expected 0", p, lk); end
    end
  endtask

  task automatic test_write_lookup();
    logic [RW-1:0] got, exp;
    logic [25:0] lk;
    int lat;
    exp_q.push_back(r_write);
    run_op(TLBWI, 5'd5, {19'h12345, 8'd3}, lo(20'h00AAA, 3'd0, 1'b0, 1'b1, 1'b0),
           lo(20'h00BBB, 3'd0, 1'b1, 1'b1, 1'b0), got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbwi_resp: got %h expected %h", got, exp); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL tlbwi_latency: got %0d expected 1", lat); end
    lookup(1, 20'h2468B, 8'd3, lk);
    n_checks++; if (lk !== {3'b111, 20'h00BBB, 3'd0}) begin n_fail++; $display("FAIL lookup_odd_page: got %h expected %h", lk, {3'b111, 20'h00BBB, 3'd0}); end
    lookup(1, 20'h2468B, 8'd4, lk);
    n_checks++; if (lk !== 26'd0) begin n_fail++; $display("FAIL lookup_asid_miss: got %h expected 0", lk); end
    lookup(0, 20'h2468A, 8'd3, lk);
    n_checks++; if (lk !== {3'b110, 20'h00AAA, 3'd0}) begin n_fail++; $display("FAIL lookup_even_page: got %h expected %h", lk, {3'b110, 20'h00AAA, 3'd0}); end
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, {19'h12345, 8'd3}, lo(20'h00AAA, 3'd0, 1'b0, 1'b1, 1'b0),
                       lo(20'h00BBB, 3'd0, 1'b1, 1'b1, 1'b0), 1'b0));
    run_op(TLBR, 5'd5, 27'd0, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbr_idx5: got %h expected %h", got, exp); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL tlbr_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_tlbp_multi();
    logic [RW-1:0] got, exp;
    logic [25:0] lk;
    int lat;
    exp_q.push_back(r_write);
    run_op(TLBWI, 5'd7, {19'h12345, 8'd9}, lo(20'h00777, 3'd0, 1'b0, 1'b1, 1'b1),
           lo(20'h00778, 3'd0, 1'b0, 1'b1, 1'b1), got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL write_idx7: got %h expected %h", got, exp); end
    exp_q.push_back(mk(1'b1, 1'b0, 5'd7, 27'd0, 26'd0, 26'd0, 1'b0));
    run_op(TLBP, 5'd0, {19'h12345, 8'd1}, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbp_global: got %h expected %h", got, exp); end
    exp_q.push_back(r_write);
    run_op(TLBWI, 5'd2, {19'h12345, 8'd1}, lo(20'h00222, 3'd0, 1'b0, 1'b1, 1'b0),
           lo(20'h00223, 3'd0, 1'b0, 1'b1, 1'b1), got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL write_idx2: got %h expected %h", got, exp); end
    exp_q.push_back(mk(1'b1, 1'b1, 5'd2, 27'd0, 26'd0, 26'd0, 1'b0));
    run_op(TLBP, 5'd0, {19'h12345, 8'd1}, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbp_multi: got %h expected %h", got, exp); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL tlbp_latency: got %0d expected 2", lat); end
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, {19'h12345, 8'd1}, lo(20'h00222, 3'd0, 1'b0, 1'b1, 1'b0),
                       lo(20'h00223, 3'd0, 1'b0, 1'b1, 1'b0), 1'b0));
    run_op(TLBR, 5'd2, 27'd0, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbr_mixed_g: got %h expected %h", got, exp); end
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, {19'h12345, 8'd9}, lo(20'h00777, 3'd0, 1'b0, 1'b1, 1'b1),
                       lo(20'h00778, 3'd0, 1'b0, 1'b1, 1'b1), 1'b0));
    run_op(TLBR, 5'd7, 27'd0, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbr_global: got %h expected %h", got, exp); end
    lookup(2, 20'h2468A, 8'd1, lk);
    n_checks++; if (lk !== {3'b110, 20'h00222, 3'd0}) begin n_fail++; $display("FAIL lookup_lowest_index: got %h expected %h", lk, {3'b110, 20'h00222, 3'd0}); end
    lookup(2, 20'h2468A, 8'h55, lk);
    n_checks++; if (lk !== {3'b110, 20'h00777, 3'd0}) begin n_fail++; $display("FAIL lookup_global: got %h expected %h", lk, {3'b110, 20'h00777, 3'd0}); end
  endtask

  task automatic test_random();
    logic [RW-1:0] got, exp;
    logic [4:0] walk [8];
    int lat;
    walk = '{5'd30, 5'd29, 5'd28, 5'd31, 5'd30, 5'd29, 5'd28, 5'd31};
    bus.wired = 5'd31;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.random_out !== 5'd31) begin n_fail++; $display("FAIL random_wired_max: got %0d expected 31", bus.random_out); end
    end
    bus.wired = 5'd28; bus.wired_we = 1'b1;
    @(negedge clk);
    bus.wired_we = 1'b0;
    n_checks++; if (bus.random_out !== 5'd31) begin n_fail++; $display("FAIL random_start: got %0d expected 31", bus.random_out); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (bus.random_out !== walk[k]) begin n_fail++; $display("FAIL random_walk_%0d: got %0d expected %0d", k, bus.random_out, walk[k]); end
    end
    @(negedge clk);
    n_checks++; if (bus.random_out !== 5'd30) begin n_fail++; $display("FAIL random_pre_we: got %0d expected 30", bus.random_out); end
    bus.wired_we = 1'b1;
    @(negedge clk);
    bus.wired_we = 1'b0;
    n_checks++; if (bus.random_out !== 5'd31) begin n_fail++; $display("FAIL random_wired_we: got %0d expected 31", bus.random_out); end
    @(negedge clk);
    n_checks++; if (bus.random_out !== 5'd30) begin n_fail++; $display("FAIL random_after_we: got %0d expected 30", bus.random_out); end
    exp_q.push_back(r_write);
    run_op(TLBWR, 5'd3, {19'h30F0F, 8'h21}, lo(20'hCAFE0, 3'd2, 1'b1, 1'b1, 1'b1),
           lo(20'h0BEEF, 3'd5, 1'b0, 1'b1, 1'b1), got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbwr_resp: got %h expected %h", got, exp); end
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, {19'h30F0F, 8'h21}, lo(20'hCAFE0, 3'd2, 1'b1, 1'b1, 1'b1),
                       lo(20'h0BEEF, 3'd5, 1'b0, 1'b1, 1'b1), 1'b0));
    run_op(TLBR, 5'd30, 27'd0, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbwr_slot30: got %h expected %h", got, exp); end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('0);
      run_op(TLBR, (k == 0) ? 5'd29 : 5'd3, 27'd0, 26'd0, 26'd0, got, lat);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tlbwr_other_slot_%0d: got %h expected %h", k, got, exp); end
    end
  endtask

  task automatic test_commit_timing();
    logic [RW-1:0] exp;
    logic [25:0] lk, want;
    want = {3'b111, 20'h11111, 3'd3};
    exp_q.push_back(r_write);
    bus.op_valid = 1'b1; bus.op_code = TLBWI; bus.op_index = 5'd5;
    bus.entryhi_in = {19'h00ABC, 8'd3};
    bus.entrylo0_in = lo(20'h11111, 3'd3, 1'b1, 1'b1, 1'b0);
    bus.entrylo1_in = 26'd0;
    bus.cur_asid = 8'd3;
    for (int p = 0; p < NR_PORT; p++) begin
      bus.lk_req[p] = 1'b1; bus.lk_vpn[20*p +: 20] = 20'h01578;
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    n_checks++; if ({bus.resp_valid, bus.op_ready} !== 2'b10) begin n_fail++; $display("FAIL commit_valid_ready: got %b expected 10", {bus.resp_valid, bus.op_ready}); end
    exp = exp_q.pop_front();
    n_checks++; if (resp_now() !== exp) begin n_fail++; $display("FAIL commit_resp: got %h expected %h", resp_now(), exp); end
    for (int p = 0; p < NR_PORT; p++) begin
      lk = {bus.lk_hit[p], bus.lk_v[p], bus.lk_d[p], bus.lk_pfn[20*p +: 20], bus.lk_c[3*p +: 3]};
      n_checks++; if (lk !== 26'd0) begin n_fail++; $display("FAIL commit_old_p%0d: got %h expected 0", p, lk); end
    end
    @(negedge clk);
    n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL commit_idle: got %b expected 1", bus.op_ready); end
    for (int p = 0; p < NR_PORT; p++) begin
      bus.lk_req[p] = 1'b0; bus.lk_vpn[20*p +: 20] = 20'h2468B;
      lk = {bus.lk_hit[p], bus.lk_v[p], bus.lk_d[p], bus.lk_pfn[20*p +: 20], bus.lk_c[3*p +: 3]};
      n_checks++; if (lk !== want) begin n_fail++; $display("FAIL commit_new_p%0d: got %h expected %h", p, lk, want); end
    end
    @(negedge clk);
    for (int p = 0; p < NR_PORT; p++) begin
      lk = {bus.lk_hit[p], bus.lk_v[p], bus.lk_d[p], bus.lk_pfn[20*p +: 20], bus.lk_c[3*p +: 3]};
      n_checks++; if (lk !== want) begin n_fail++; $display("FAIL lookup_hold_p%0d: got %h expected %h", p, lk, want); end
    end
    lookup(0, 20'h2468B, 8'd3, lk);
    n_checks++; if (lk !== {3'b110, 20'h00778, 3'd0}) begin n_fail++; $display("FAIL lookup_after_overwrite: got %h expected %h", lk, {3'b110, 20'h00778, 3'd0}); end
  endtask

  task automatic test_reset_midop();
    logic [RW-1:0] got, exp;
    logic [25:0] lk;
    logic [19:0] vpns [3];
    int lat, seen_valid, not_ready;
    vpns = '{20'h2468B, 20'h01578, 20'h61E1E};
    seen_valid = 0; not_ready = 0;
    bus.op_valid = 1'b1; bus.op_code = TLBP; bus.entryhi_in = {19'h12345, 8'd1};
    @(negedge clk);
    bus.op_valid = 1'b0;
    n_checks++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL pcmp_busy: got %b expected 0", bus.op_ready); end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen_valid++;
    end
    n_checks++; if (bus.random_out !== 5'd31) begin n_fail++; $display("FAIL midop_reset_random: got %0d expected 31", bus.random_out); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen_valid++;
      if (bus.op_ready !== 1'b1) not_ready++;
    end
    n_checks++; if (seen_valid != 0) begin n_fail++; $display("FAIL midop_resp_dropped: got %0d pulses expected 0", seen_valid); end
    n_checks++; if (not_ready != 0) begin n_fail++; $display("FAIL midop_ready: got %0d busy cycles expected 0", not_ready); end
    for (int k = 0; k < 3; k++) begin
      lookup(k, vpns[k], (k == 2) ? 8'h21 : 8'd3, lk);
      n_checks++; if (lk !== 26'd0) begin n_fail++; $display("FAIL midop_entries_cleared_%0d: got %h expected 0", k, lk); end
    end
    exp_q.push_back('0);
    run_op(TLBP, 5'd0, {19'h12345, 8'd1}, 26'd0, 26'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL midop_tlbp_miss: got %h expected %h", got, exp); end
  endtask

  initial begin
    r_write = {{(RW-1){1'b0}}, 1'b1};
    bus.op_valid = 1'b0; bus.op_code = 2'd0; bus.op_index = 5'd0;
    bus.entryhi_in = 27'd0; bus.entrylo0_in = 26'd0; bus.entrylo1_in = 26'd0;
    bus.wired = 5'd0; bus.wired_we = 1'b0; bus.cur_asid = 8'd0;
    bus.lk_req = '0; bus.lk_vpn = '0;
    test_reset();
    test_write_lookup();
    test_tlbp_multi();
    test_random();
    test_commit_timing();
    test_reset_midop();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
